// File: rtl/decode_pkg.sv
// Shared decode definitions: opcodes, funct fields, ALU op enum, bundle struct.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package decode_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_NONE = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SUB  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7,
      ALU_SRA  = 4'd8,
      ALU_SLT  = 4'd9,
      ALU_SLTU = 4'd10
   } alu_op_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [XLEN-1:0] imm;
      alu_op_e         alu_op;
      logic            is_from_rf;
      logic            rf_we;
      logic            illegal;
   } dec_bundle_t;

endpackage

// File: rtl/decode_stage_if.sv
// Handshake bundles between fetch, decode and the register-file/ALU stage.
// Latency: none (wiring only).
// Backpressure: valid/ready on both sides; master drives valid and data.
interface decode_in_if #(parameter int XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;

   modport master (output in_valid, in_instr, in_pc, input in_ready);
   modport slave  (input in_valid, in_instr, in_pc, output in_ready);
endinterface

interface decode_out_if #(parameter int XLEN = 32);
   logic                 out_valid;
   logic                 out_ready;
   logic [XLEN-1:0]      out_pc;
   logic [4:0]           out_rd;
   logic [4:0]           out_rs1;
   logic [4:0]           out_rs2;
   logic [XLEN-1:0]      out_imm;
   decode_pkg::alu_op_e  out_alu_op;
   logic                 out_is_from_rf;
   logic                 out_rf_we;
   logic                 out_illegal;

   modport master (output out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
                   out_alu_op, out_is_from_rf, out_rf_we, out_illegal,
                   input out_ready);
   modport slave  (input out_valid, out_pc, out_rd, out_rs1, out_rs2, out_imm,
                   out_alu_op, out_is_from_rf, out_rf_we, out_illegal,
                   output out_ready);
endinterface

// File: rtl/decode_stage_skid_buffer.sv
// Two-entry skid buffer (main M, skid S) for a W-bit payload.
// Latency: 1 cycle when M is empty; full throughput with out_rdy held high.
// Backpressure: in_rdy = !S valid, a pure flop output; flush empties both entries.
module skid_buffer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         in_vld,
   output logic         in_rdy,
   input  logic [W-1:0] in_dat,
   output logic         out_vld,
   input  logic         out_rdy,
   output logic [W-1:0] out_dat
);

   logic         m_vld_q, m_vld_d;
   logic         s_vld_q, s_vld_d;
   logic [W-1:0] m_dat_q, m_dat_d;
   logic [W-1:0] s_dat_q, s_dat_d;
   logic         accept;
   logic         m_free;

   assign in_rdy  = ~s_vld_q;
   assign out_vld = m_vld_q;
   assign out_dat = m_dat_q;

   // Next-state for M/S: refill M from S first, new words go to M when it frees up, else to S.
   always_comb begin
      m_vld_d = m_vld_q;
      s_vld_d = s_vld_q;
      m_dat_d = m_dat_q;
      s_dat_d = s_dat_q;
      accept  = in_vld & ~s_vld_q & ~flush;
      m_free  = ~m_vld_q | out_rdy;
      if (flush) begin
         m_vld_d = 1'b0;
         s_vld_d = 1'b0;
      end else if (m_free) begin
         if (s_vld_q) begin
            m_vld_d = 1'b1;
            m_dat_d = s_dat_q;
            s_vld_d = 1'b0;
         end else if (accept) begin
            m_vld_d = 1'b1;
            m_dat_d = in_dat;
         end else begin
            m_vld_d = 1'b0;
         end
      end else if (accept) begin
         s_vld_d = 1'b1;
         s_dat_d = in_dat;
      end
   end

   // State registers; data fields clear on reset so outputs read as zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_vld_q <= 1'b0;
         s_vld_q <= 1'b0;
         m_dat_q <= '0;
         s_dat_q <= '0;
      end else begin
         m_vld_q <= m_vld_d;
         s_vld_q <= s_vld_d;
         m_dat_q <= m_dat_d;
         s_dat_q <= s_dat_d;
      end
   end

endmodule

// File: rtl/decode_stage.sv
// RV32I ALU-subset + LUI decoder feeding a registered skid buffer; counts illegal bundles.
// Latency: 1 cycle from accept to out_valid; one instruction per cycle.
// Backpressure: in_ready is a registered "skid empty"; out_ready never reaches in_ready combinationally.
module decode_stage import decode_pkg::*; #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   decode_in_if.slave       in_if,
   decode_out_if.master     out_if,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam int BW = $bits(dec_bundle_t);

   dec_bundle_t     dec;
   dec_bundle_t     ob;
   logic [BW-1:0]   ob_dat;
   logic            legal;
   logic [XLEN-1:0] imm;
   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign opc = in_if.in_instr[6:0];
   assign f3  = in_if.in_instr[14:12];
   assign f7  = in_if.in_instr[31:25];

   // Instruction decode: illegal encodings collapse to a NOP-like bundle keeping pc and register fields.
   always_comb begin
      legal          = 1'b0;
      imm            = '0;
      dec.pc         = in_if.in_pc;
      dec.rd         = in_if.in_instr[11:7];
      dec.rs1        = in_if.in_instr[19:15];
      dec.rs2        = in_if.in_instr[24:20];
      dec.imm        = '0;
      dec.alu_op     = ALU_NONE;
      dec.is_from_rf = 1'b0;
      dec.rf_we      = 1'b0;
      dec.illegal    = 1'b0;
      unique case (opc)
         OPC_OP_IMM: begin
            legal = 1'b1;
            imm   = XLEN'($signed(in_if.in_instr[31:20]));
            unique case (f3)
               F3_ADD_SUB: dec.alu_op = ALU_ADD;
               F3_SLT:     dec.alu_op = ALU_SLT;
               F3_SLTU:    dec.alu_op = ALU_SLTU;
               F3_XOR:     dec.alu_op = ALU_XOR;
               F3_OR:      dec.alu_op = ALU_OR;
               F3_AND:     dec.alu_op = ALU_AND;
               F3_SLL: begin
                  imm        = XLEN'(in_if.in_instr[24:20]);
                  dec.alu_op = ALU_SLL;
                  legal      = (f7 == F7_BASE);
               end
               default: begin
                  imm        = XLEN'(in_if.in_instr[24:20]);
                  dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
            endcase
         end
         OPC_OP: begin
            dec.is_from_rf = 1'b1;
            legal          = (f7 == F7_BASE);
            unique case (f3)
               F3_ADD_SUB: begin
                  dec.alu_op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                  legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
               F3_SRL_SRA: begin
                  dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
               end
               F3_SLL:  dec.alu_op = ALU_SLL;
               F3_SLT:  dec.alu_op = ALU_SLT;
               F3_SLTU: dec.alu_op = ALU_SLTU;
               F3_XOR:  dec.alu_op = ALU_XOR;
               F3_OR:   dec.alu_op = ALU_OR;
               default: dec.alu_op = ALU_AND;
            endcase
         end
         OPC_LUI: begin
            legal      = 1'b1;
            dec.alu_op = ALU_ADD;
            dec.rs1    = 5'd0;
            imm        = XLEN'($signed({in_if.in_instr[31:12], 12'b0}));
         end
         default: legal = 1'b0;
      endcase
      if (legal) begin
         dec.imm   = imm;
         dec.rf_we = (dec.rd != 5'd0);
      end else begin
         dec.alu_op     = ALU_NONE;
         dec.is_from_rf = 1'b0;
         dec.illegal    = 1'b1;
      end
   end

   skid_buffer #(.W(BW)) u_skid (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .in_vld  (in_if.in_valid),
      .in_rdy  (in_if.in_ready),
      .in_dat  (dec),
      .out_vld (out_if.out_valid),
      .out_rdy (out_if.out_ready),
      .out_dat (ob_dat)
   );

   assign ob                    = dec_bundle_t'(ob_dat);
   assign out_if.out_pc         = ob.pc;
   assign out_if.out_rd         = ob.rd;
   assign out_if.out_rs1        = ob.rs1;
   assign out_if.out_rs2        = ob.rs2;
   assign out_if.out_imm        = ob.imm;
   assign out_if.out_alu_op     = ob.alu_op;
   assign out_if.out_is_from_rf = ob.is_from_rf;
   assign out_if.out_rf_we      = ob.rf_we;
   assign out_if.out_illegal    = ob.illegal;
   assign illegal_cnt           = cnt_q;

   // Illegal counter: count delivered illegal bundles (flush does not block the handshake), saturating.
   always_comb begin
      cnt_d = cnt_q;
      if (out_if.out_valid && out_if.out_ready && ob.illegal && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic [15:0] illegal_cnt;
   int          n_chk;
   int          n_err;

   decode_in_if  #(.XLEN(32)) in_if ();
   decode_out_if #(.XLEN(32)) out_if ();

   decode_stage #(.XLEN(32), .CNT_W(16)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_if       (in_if),
      .out_if      (out_if),
      .illegal_cnt (illegal_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
      in_if.in_valid = v;
      in_if.in_instr = instr;
      in_if.in_pc    = pc;
   endtask

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
      return {imm, 5'd0, 3'b000, rd, 7'b0010011};
   endfunction

   logic [4:0]  got_rd[$];
   logic [31:0] strm[4];
   int          idx;
   int          cyc;
   logic        hs_out;
   logic        hs_in;
   logic [4:0]  rd_now;
   logic        seen;

   initial begin
      n_chk = 0;
      n_err = 0;
      rst_n = 1'b0;
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      out_if.out_ready = 1'b0;
      #12;
      check("rst_in_ready", 32'(in_if.in_ready), 32'd1);
      check("rst_out_valid", 32'(out_if.out_valid), 32'd0);
      check("rst_cnt", 32'(illegal_cnt), 32'd0);
      check("rst_imm", out_if.out_imm, 32'd0);
      check("rst_rd", 32'(out_if.out_rd), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_in_ready", 32'(in_if.in_ready), 32'd1);

      // ADDI x1,x0,-1
      drive(1'b1, 32'hFFF00093, 32'h100);
      out_if.out_ready = 1'b1;
      tick();
      check("addi_valid", 32'(out_if.out_valid), 32'd1);
      check("addi_rd", 32'(out_if.out_rd), 32'd1);
      check("addi_imm", out_if.out_imm, 32'hFFFFFFFF);
      check("addi_op", 32'(out_if.out_alu_op), 32'd1);
      check("addi_we", 32'(out_if.out_rf_we), 32'd1);
      check("addi_rf", 32'(out_if.out_is_from_rf), 32'd0);
      check("addi_pc", out_if.out_pc, 32'h100);

      // SUB x3,x1,x2 then SRAI x4,x1,3 back to back
      drive(1'b1, 32'h402081B3, 32'h104);
      tick();
      check("sub_op", 32'(out_if.out_alu_op), 32'd5);
      check("sub_imm", out_if.out_imm, 32'd0);
      check("sub_rf", 32'(out_if.out_is_from_rf), 32'd1);
      check("sub_regs", {17'd0, out_if.out_rd, out_if.out_rs1, out_if.out_rs2}, {17'd0, 5'd3, 5'd1, 5'd2});
      drive(1'b1, 32'h4030D213, 32'h108);
      tick();
      check("srai_valid", 32'(out_if.out_valid), 32'd1);
      check("srai_op", 32'(out_if.out_alu_op), 32'd8);
      check("srai_imm", out_if.out_imm, 32'd3);
      check("srai_rd", 32'(out_if.out_rd), 32'd4);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("idle_valid", 32'(out_if.out_valid), 32'd0);

      // Stream 4 with back-pressure
      for (int k = 0; k < 4; k++) strm[k] = addi(5'(k + 1), 12'(k + 1));
      out_if.out_ready = 1'b0;
      drive(1'b1, strm[0], 32'h200);
      tick();
      check("strm_rdy1", 32'(in_if.in_ready), 32'd1);
      drive(1'b1, strm[1], 32'h204);
      tick();
      check("strm_rdy2", 32'(in_if.in_ready), 32'd0);
      check("strm_hold_rd", 32'(out_if.out_rd), 32'd1);
      drive(1'b1, strm[2], 32'h208);
      tick();
      check("strm_stall_rd", 32'(out_if.out_rd), 32'd1);
      check("strm_stall_rdy", 32'(in_if.in_ready), 32'd0);
      idx = 2;
      out_if.out_ready = 1'b1;
      cyc = 0;
      while (cyc < 20 && got_rd.size() < 4) begin
         hs_out = out_if.out_valid & out_if.out_ready;
         rd_now = out_if.out_rd;
         hs_in  = in_if.in_valid & in_if.in_ready;
         tick();
         if (hs_out) got_rd.push_back(rd_now);
         if (hs_in) idx++;
         if (idx < 4) drive(1'b1, strm[idx], 32'h200 + 32'(idx * 4));
         else         drive(1'b0, 32'h0, 32'h0);
         cyc++;
      end
      check("strm_count", 32'(got_rd.size()), 32'd4);
      for (int k = 0; k < 4; k++)
         check("strm_order", (k < got_rd.size()) ? 32'(got_rd[k]) : 32'hDEAD, 32'(k + 1));
      tick();
      check("strm_no_dup", 32'(out_if.out_valid), 32'd0);

      // Illegal encodings
      drive(1'b1, 32'h00000000, 32'h300);
      tick();
      check("ill0_flag", 32'(out_if.out_illegal), 32'd1);
      check("ill0_we", 32'(out_if.out_rf_we), 32'd0);
      check("ill0_op", 32'(out_if.out_alu_op), 32'd0);
      drive(1'b1, 32'h021081B3, 32'h304);
      tick();
      check("ill1_flag", 32'(out_if.out_illegal), 32'd1);
      check("ill1_rf", 32'(out_if.out_is_from_rf), 32'd0);
      check("ill1_rd", 32'(out_if.out_rd), 32'd3);
      check("ill1_pc", out_if.out_pc, 32'h304);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("ill_cnt2", 32'(illegal_cnt), 32'd2);

      // rd=0 and LUI
      drive(1'b1, 32'h00500013, 32'h400);
      tick();
      check("x0_we", 32'(out_if.out_rf_we), 32'd0);
      check("x0_ill", 32'(out_if.out_illegal), 32'd0);
      check("x0_imm", out_if.out_imm, 32'd5);
      drive(1'b1, 32'h800002B7, 32'h404);
      tick();
      check("lui_imm", out_if.out_imm, 32'h80000000);
      check("lui_rs1", 32'(out_if.out_rs1), 32'd0);
      check("lui_op", 32'(out_if.out_alu_op), 32'd1);
      check("lui_we", 32'(out_if.out_rf_we), 32'd1);
      drive(1'b1, 32'h000F82B7, 32'h408);
      tick();
      check("lui2_rs1", 32'(out_if.out_rs1), 32'd0);
      check("lui2_imm", out_if.out_imm, 32'h000F8000);
      drive(1'b0, 32'h0, 32'h0);
      tick();

      // Flush with M and S full
      out_if.out_ready = 1'b0;
      drive(1'b1, addi(5'd6, 12'd6), 32'h500);
      tick();
      drive(1'b1, addi(5'd7, 12'd7), 32'h504);
      tick();
      check("fl_full_rdy", 32'(in_if.in_ready), 32'd0);
      flush = 1'b1;
      drive(1'b1, addi(5'd8, 12'd8), 32'h508);
      tick();
      flush = 1'b0;
      check("fl_valid", 32'(out_if.out_valid), 32'd0);
      check("fl_rdy", 32'(in_if.in_ready), 32'd1);
      drive(1'b0, 32'h0, 32'h0);
      out_if.out_ready = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (out_if.out_valid) seen = 1'b1;
      end
      check("fl_dropped", 32'(seen), 32'd0);

      // Flush with in_ready=1 and an illegal bundle handshaking in the flush cycle
      drive(1'b1, 32'h00000000, 32'h600);
      tick();
      check("fl2_m_ill", 32'(out_if.out_illegal), 32'd1);
      flush = 1'b1;
      drive(1'b1, addi(5'd9, 12'd9), 32'h604);
      tick();
      flush = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      check("fl2_valid", 32'(out_if.out_valid), 32'd0);
      check("fl2_cnt", 32'(illegal_cnt), 32'd3);
      tick();
      check("fl2_dropped", 32'(out_if.out_valid), 32'd0);

      // Saturation
      drive(1'b1, 32'h00000000, 32'h700);
      repeat (65540) @(posedge clk);
      #1;
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("sat_cnt", 32'(illegal_cnt), 32'h0000FFFF);
      drive(1'b1, 32'h00000000, 32'h704);
      tick();
      drive(1'b0, 32'h0, 32'h0);
      tick();
      check("sat_hold", 32'(illegal_cnt), 32'h0000FFFF);

      // Asynchronous reset mid-stream
      out_if.out_ready = 1'b0;
      drive(1'b1, addi(5'd10, 12'd10), 32'h800);
      tick();
      drive(1'b1, addi(5'd11, 12'd11), 32'h804);
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(out_if.out_valid), 32'd0);
      check("arst_rdy", 32'(in_if.in_ready), 32'd1);
      check("arst_cnt", 32'(illegal_cnt), 32'd0);
      check("arst_rd", 32'(out_if.out_rd), 32'd0);
      drive(1'b0, 32'h0, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("arst_after", 32'(out_if.out_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, handshaked instruction-decode stage for the RV32I core, successor to the combinational control decoder. It accepts one instruction per cycle from fetch, decodes the full RV32I integer register/immediate ALU subset plus LUI, and presents a registered control bundle to the register-file/ALU stage. A two-entry skid buffer gives full throughput under back-pressure without a combinational ready path.

## Interface
- XLEN, 32: datapath width; immediate and PC width.
- CNT_W, 16: width of the illegal-instruction counter.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  fetch has an instruction.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  synchronous kill of all held entries.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts.
- out_pc  out  XLEN  PC of bundle.
- out_rd, out_rs1, out_rs2  out  5 each  register indices.
- out_imm  out  XLEN  sign-extended immediate.
- out_alu_op  out  4  ALU operation.
- out_is_from_rf  out  1  operand B from rs2 (else out_imm).
- out_rf_we  out  1  register write enable.
- out_illegal  out  1  instruction not supported.
- illegal_cnt  out  CNT_W  saturating count of illegal bundles delivered.

## Operation
- ALU op codes: 0 NONE, 1 ADD, 2 XOR, 3 OR, 4 AND, 5 SUB, 6 SLL, 7 SRL, 8 SRA, 9 SLT, 10 SLTU; 11–15 unused.
- OP-IMM (0010011): ADDI, SLTI, SLTIU, XORI, ORI, ANDI with imm = sext(instr[31:20]). SLLI requires instr[31:25]=0; SRLI/SRAI require instr[31:25]=0000000/0100000, imm = zext(instr[24:20]).
- OP (0110011): ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND; funct7 must be 0000000, or 0100000 for SUB/SRA; is_from_rf=1, imm=0.
- LUI (0110111): alu_op ADD, rs1 forced 0, imm = {instr[31:12], 12'b0} sign-extended to XLEN.
- Any other encoding, or bad funct7: illegal=1, alu_op=0, rf_we=0, is_from_rf=0, imm=0; rd/rs1/rs2/pc still passed.
- rd = 0 forces rf_we=0 (not illegal).
- Skid buffer: main register M and skid register S. Accept when in_valid AND in_ready. If M empty or M drains this cycle, the decoded word goes to M; otherwise to S. When M drains and S is full, S moves to M.
- illegal_cnt increments on out_valid AND out_ready AND out_illegal; saturates at all-ones.

## Timing
- Reset: out_valid=0, S empty, all out_* data fields 0, illegal_cnt=0; in_ready=1 during and after reset.
- Latency: instruction accepted in cycle N appears on out_* in cycle N+1 (M empty).
- Throughput 1/cycle with out_ready held high.
- out_* stable while out_valid=1 and out_ready=0.
- in_ready is a pure register output; no path from out_ready to in_ready.
- flush: at the next edge M and S are emptied. An instruction offered in the flush cycle is dropped even if in_ready=1. A handshake on out_* in the flush cycle still completes and counts. Flush has priority over everything else.
- Reset asserted mid-stream clears all state immediately (asynchronously); no partial bundle survives.

## Structure
- Shared package decode_pkg: opcode constants (OP_IMM, OP, LUI), funct3/funct7 constants, ALU op enum (4-bit), packed decoded-bundle struct. The ALU imports the same enum.
- One combinational function/always block for decode; sub-module skid_buffer, parametrised on payload width, holding M/S and the handshake; decode_stage instantiates it with the bundle struct.

## Test plan
- Reset then ADDI x1,x0,-1 (0xFFF00093) -> next cycle out_valid=1, rd=1, imm=0xFFFFFFFF, alu_op=1, rf_we=1, is_from_rf=0.
- SUB x3,x1,x2 (0x402081B3) then SRAI x4,x1,3 (0x4030D213) back-to-back, out_ready=1 -> alu_op 5 then 8, imm 0 then 3, one per cycle.
- Stream 4 instructions with out_ready=0 from cycle 2 -> in_ready drops after second accept; on out_ready=1 all 4 delivered in order, none lost or duplicated.
- Instruction 0x00000000 and ADD with funct7=0000001 (0x021081B3) -> out_illegal=1, rf_we=0, alu_op=0, illegal_cnt=2 after both handshakes.
- ADDI x0,x0,5 (0x00500013) -> rf_we=0, illegal=0; LUI x5,0x80000 (0x800002B7) -> imm=0x80000000, rs1=0, alu_op=1.
- With M and S full, assert flush alongside in_valid -> next cycle out_valid=0, in_ready=1, offered instruction never appears; preset illegal_cnt to 0xFFFF and deliver illegal -> stays 0xFFFF.
